sample_buffer: RTL and testbench
================================

SAMPLE_BUFFER -- requirements
Module: sample_buffer

Interface
REQ-001 SHALL have parameter N, default 16: complex points per frame, power of two.
REQ-002 SHALL have parameter DATA_W, default 8: sample width in bits.
REQ-003 SHALL have port clk  input  1: single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port run  input  1: capture window from the sampler, high for the whole frame.
REQ-006 SHALL have port sample  input  1: one-cycle write strobe from the sampler.
REQ-007 SHALL have port imag  input  1: part select, 0 = real and 1 = imaginary, valid with sample.
REQ-008 SHALL have port addr  input  $clog2(N): point index, valid with sample.
REQ-009 SHALL have port din  input  DATA_W: ADC sample data, valid with sample.
REQ-010 SHALL have port frame_ack  input  1: FFT side releases the frame.
REQ-011 SHALL have port rd_addr  input  $clog2(N): FFT-side read index.
REQ-012 SHALL have ports rd_re and rd_im  output  DATA_W each: registered read data.
REQ-013 SHALL have port frame_ready  output  1: a complete frame is held and may be read.
REQ-014 SHALL have ports short_frame and overflow  output  1 each: sticky error flags.

Function
REQ-015 SHALL implement states IDLE, FILL and READY, encoded in the package.
- IDLE to FILL: run=1.
- FILL to READY: run=0.
- READY to IDLE: frame_ack=1.
- frame_ack in IDLE or FILL: ignored.
REQ-016 SHALL write din into re_mem[addr] (imag=0) or im_mem[addr] (imag=1) on a cycle where sample=1, run=1 and state is IDLE or FILL.
REQ-017 SHALL ignore writes in READY; a sample=1 in READY SHALL set overflow.
REQ-018 SHALL count accepted writes in a $clog2(2N)+1-bit counter, cleared on entry to FILL from IDLE.
REQ-019 SHALL set short_frame on the FILL to READY transition when the write count is not equal to 2N.
REQ-020 SHALL drive frame_ready=1 exactly while state is READY, with no combinational path from inputs.
REQ-021 SHALL update rd_re/rd_im one cycle after rd_addr, in every state.
REQ-022 SHALL return the old memory content on a same-cycle read and write to the same address.
REQ-023 SHALL store the last write when duplicate writes hit the same addr/imag pair.
REQ-024 SHALL return to IDLE on frame_ack=1 with run=1 in the same cycle, and enter FILL on the next cycle.
REQ-025 SHALL clear overflow and short_frame on frame_ack in READY.
REQ-026 SHALL keep addr wrap-around a sampler concern; out-of-range addr cannot occur because N is a power of two.

Reset
REQ-027 SHALL force the following while reset=1, independent of clk:
- state to IDLE;
- frame_ready, short_frame and overflow to 0;
- write counter to 0;
- rd_re and rd_im to 0.
REQ-028 SHALL leave memory contents undefined and unreset; reset mid-FILL abandons the frame.

Configuration
REQ-029 SHALL support macro SAMPLE_BUFFER_OFFSET_BIN_EN.
- Defined: din is offset-binary, and its MSB is inverted before the write to store two's complement.
- Undefined: din is stored unchanged.
- Read path and latency SHALL be identical in both cases.

Structure
REQ-030 SHALL take the state enum and the DATA_W and N default constants from shared package fft_pkg.
REQ-031 SHALL place both memories in one sub-module, sample_ram: two arrays, one write port, one registered read port.

Verification
REQ-032 Full frame (N=16, DATA_W=8): 32 strobes, real = addr, imag = 0x80+addr; reading rd_addr 0..15 gives rd_re=k and rd_im=0x80+k one cycle later; frame_ready=1; short_frame=0.
REQ-033 Short frame: run falls after 20 strobes; frame_ready=1 and short_frame=1; frame_ack then clears both.
REQ-034 Overflow: sample=1 with run=1 during READY; overflow=1 and the memory at that addr is unchanged.
REQ-035 Reset mid-FILL: reset at write 10; all outputs 0 and state IDLE; a following full frame captures correctly.
REQ-036 Same cycle: frame_ack with run=1 in READY; state is IDLE then FILL; first strobe addr 0 is written.
REQ-037 Macro: with SAMPLE_BUFFER_OFFSET_BIN_EN, din=0x80 reads back 0x00 and din=0x00 reads back 0x80; without the macro, both read back unchanged.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT front-end definitions: sample buffer state encoding and default sizes.
package fft_pkg;

   localparam int unsigned N_DEFAULT      = 16;
   localparam int unsigned DATA_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFill  = 2'd1,
      StReady = 2'd2
   } buf_state_e;

   // The sampler owns the buffer everywhere except while a frame is held for the FFT.
   function automatic logic is_capture(buf_state_e s);
      return s != StReady;
   endfunction

endpackage

// File: rtl/sample_ram.sv
// Real and imaginary sample storage: one shared write port, one registered read port.
module sample_ram #(
   parameter int unsigned N      = 16,
   parameter int unsigned DATA_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 we,
   input  logic                 we_imag,
   input  logic [$clog2(N)-1:0] wr_addr,
   input  logic [DATA_W-1:0]    wr_data,
   input  logic [$clog2(N)-1:0] rd_addr,
   output logic [DATA_W-1:0]    rd_re,
   output logic [DATA_W-1:0]    rd_im
);

   logic [DATA_W-1:0] re_mem [N];
   logic [DATA_W-1:0] im_mem [N];

   logic [DATA_W-1:0] rd_re_q, rd_re_d;
   logic [DATA_W-1:0] rd_im_q, rd_im_d;

   always_ff @(posedge clk) begin
      if (we) begin
         if (we_imag) begin
            im_mem[wr_addr] <= wr_data;
         end else begin
            re_mem[wr_addr] <= wr_data;
         end
      end
   end

   // Non-blocking write above means a colliding read returns the pre-write content.
   always_comb begin
      rd_re_d = re_mem[rd_addr];
      rd_im_d = im_mem[rd_addr];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_re_q <= '0;
         rd_im_q <= '0;
      end else begin
         rd_re_q <= rd_re_d;
         rd_im_q <= rd_im_d;
      end
   end

   assign rd_re = rd_re_q;
   assign rd_im = rd_im_q;

endmodule

// File: rtl/sample_buffer.sv
// Ping-free capture buffer between the ADC sampler and the FFT: fill, hold, release.
// Build option SAMPLE_BUFFER_OFFSET_BIN_EN converts offset-binary din to two's complement.
module sample_buffer
   import fft_pkg::*;
#(
   parameter int unsigned N      = N_DEFAULT,
   parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic                 sample,
   input  logic                 imag,
   input  logic [$clog2(N)-1:0] addr,
   input  logic [DATA_W-1:0]    din,
   input  logic                 frame_ack,
   input  logic [$clog2(N)-1:0] rd_addr,
   output logic [DATA_W-1:0]    rd_re,
   output logic [DATA_W-1:0]    rd_im,
   output logic                 frame_ready,
   output logic                 short_frame,
   output logic                 overflow
);

   localparam int unsigned CW       = $clog2(2 * N) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(2 * N);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   buf_state_e        state_q, state_d;
   logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
   logic              frame_ready_q, frame_ready_d;
   logic              short_frame_q, short_frame_d;
   logic              overflow_q, overflow_d;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;

   assign wr_en = sample & run & is_capture(state_q);

`ifdef SAMPLE_BUFFER_OFFSET_BIN_EN
   assign wr_data = {~din[DATA_W-1], din[DATA_W-2:0]};
`else
   assign wr_data = din;
`endif

   always_comb begin
      state_d       = state_q;
      wr_cnt_d      = wr_cnt_q;
      short_frame_d = short_frame_q;
      overflow_d    = overflow_q;
      unique case (state_q)
         StIdle: begin
            if (run) begin
               state_d  = StFill;
               wr_cnt_d = '0;
            end
         end
         StFill: begin
            if (!run) begin
               state_d = StReady;
               if (wr_cnt_q != FULL_CNT) begin
                  short_frame_d = 1'b1;
               end
            end
         end
         StReady: begin
            if (sample) begin
               overflow_d = 1'b1;
            end
            if (frame_ack) begin
               state_d       = StIdle;
               short_frame_d = 1'b0;
               overflow_d    = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
      // Count after the entry clear so a strobe on the IDLE->FILL cycle is kept;
      // saturate so heavy duplicate writing cannot wrap back onto 2N.
      if (wr_en && (wr_cnt_d != CNT_MAX)) begin
         wr_cnt_d = wr_cnt_d + CW'(1);
      end
      frame_ready_d = (state_d == StReady);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         wr_cnt_q      <= '0;
         frame_ready_q <= 1'b0;
         short_frame_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_cnt_q      <= wr_cnt_d;
         frame_ready_q <= frame_ready_d;
         short_frame_q <= short_frame_d;
         overflow_q    <= overflow_d;
      end
   end

   assign frame_ready = frame_ready_q;
   assign short_frame = short_frame_q;
   assign overflow    = overflow_q;

   sample_ram #(
      .N      (N),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .we      (wr_en),
      .we_imag (imag),
      .wr_addr (addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_re   (rd_re),
      .rd_im   (rd_im)
   );

endmodule

// File: tb/tb_sample_buffer.sv
// Directed bench for sample_buffer: full/short frames, overflow, reset mid-fill, ack+run.
module tb_sample_buffer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       run = 1'b0;
   logic       sample = 1'b0;
   logic       imag = 1'b0;
   logic [3:0] addr = '0;
   logic [7:0] din = '0;
   logic       frame_ack = 1'b0;
   logic [3:0] rd_addr = '0;
   logic [7:0] rd_re, rd_im;
   logic       frame_ready, short_frame, overflow;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [3:0] rd_addr;
      logic [7:0] exp_re;
      logic [7:0] exp_im;
   } rd_vec_t;

   rd_vec_t vec [16];

   sample_buffer #(
      .N      (16),
      .DATA_W (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .sample      (sample),
      .imag        (imag),
      .addr        (addr),
      .din         (din),
      .frame_ack   (frame_ack),
      .rd_addr     (rd_addr),
      .rd_re       (rd_re),
      .rd_im       (rd_im),
      .frame_ready (frame_ready),
      .short_frame (short_frame),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] sv(input logic [7:0] d);
`ifdef SAMPLE_BUFFER_OFFSET_BIN_EN
      return d ^ 8'h80;
`else
      return d;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic im, input logic [3:0] a, input logic [7:0] d);
      run    = 1'b1;
      sample = 1'b1;
      imag   = im;
      addr   = a;
      din    = d;
      tick();
      sample = 1'b0;
   endtask

   task automatic full_frame(input logic [7:0] re_base, input logic [7:0] im_base);
      run    = 1'b1;
      sample = 1'b0;
      tick();
      for (int k = 0; k < 16; k++) wr(1'b0, 4'(k), re_base + 8'(k));
      for (int k = 0; k < 16; k++) wr(1'b1, 4'(k), im_base + 8'(k));
      run    = 1'b0;
      sample = 1'b0;
      tick();
   endtask

   task automatic read_chk(input logic [3:0] a, input logic [7:0] er, input logic [7:0] ei);
      rd_addr = a;
      tick();
      check("rd_re", {24'd0, rd_re}, {24'd0, er});
      check("rd_im", {24'd0, rd_im}, {24'd0, ei});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int k = 0; k < 16; k++) begin
         vec[k] = '{rd_addr: 4'(k), exp_re: sv(8'(k)), exp_im: sv(8'h80 + 8'(k))};
      end

      // Reset state, applied between clock edges.
      #2 reset = 1'b1;
      #1;
      check("rst_frame_ready", {31'd0, frame_ready}, 0);
      check("rst_short_frame", {31'd0, short_frame}, 0);
      check("rst_overflow", {31'd0, overflow}, 0);
      check("rst_rd_re", {24'd0, rd_re}, 0);
      check("rst_rd_im", {24'd0, rd_im}, 0);
      tick();
      tick();
      reset = 1'b0;

      // Full frame: real = k, imag = 0x80 + k.
      full_frame(8'h00, 8'h80);
      check("full_frame_ready", {31'd0, frame_ready}, 1);
      check("full_short_frame", {31'd0, short_frame}, 0);
      check("full_overflow", {31'd0, overflow}, 0);

      // Read data is registered: no change before the next edge.
      rd_addr = 4'd5;
      #1;
      check("rd_latency_hold", {24'd0, rd_re}, {24'd0, sv(8'h00)});
      tick();
      check("rd_latency_upd", {24'd0, rd_re}, {24'd0, sv(8'h05)});

      for (int i = 0; i < 16; i++) begin
         rd_addr = vec[i].rd_addr;
         tick();
         check("tbl_rd_re", {24'd0, rd_re}, {24'd0, vec[i].exp_re});
         check("tbl_rd_im", {24'd0, rd_im}, {24'd0, vec[i].exp_im});
      end

      // Overflow: strobe while READY is dropped but flagged.
      wr(1'b0, 4'd3, 8'h55);
      check("ovf_flag", {31'd0, overflow}, 1);
      check("ovf_still_ready", {31'd0, frame_ready}, 1);
      read_chk(4'd3, sv(8'h03), sv(8'h83));

      // frame_ack with run=1: IDLE this edge, FILL on the next, first strobe kept.
      frame_ack = 1'b1;
      run       = 1'b1;
      tick();
      frame_ack = 1'b0;
      check("ack_frame_ready", {31'd0, frame_ready}, 0);
      check("ack_overflow", {31'd0, overflow}, 0);
      check("ack_short_frame", {31'd0, short_frame}, 0);
      wr(1'b0, 4'd0, 8'h11);
      check("fill_not_ready", {31'd0, frame_ready}, 0);

      // Short frame of 20 strobes with a same-address read/write and a duplicate write.
      for (int k = 1; k < 10; k++) begin
         if (k == 5) rd_addr = 4'd5;
         wr(1'b0, 4'(k), 8'h20 + 8'(k));
         if (k == 5) check("collide_old", {24'd0, rd_re}, {24'd0, sv(8'h05)});
         if (k == 6) check("collide_new", {24'd0, rd_re}, {24'd0, sv(8'h25)});
      end
      for (int k = 0; k < 9; k++) wr(1'b1, 4'(k), 8'h40 + 8'(k));
      wr(1'b0, 4'd1, 8'h77);
      run = 1'b0;
      tick();
      check("short_frame_ready", {31'd0, frame_ready}, 1);
      check("short_flag", {31'd0, short_frame}, 1);
      check("short_overflow", {31'd0, overflow}, 0);
      read_chk(4'd0, sv(8'h11), sv(8'h40));
      read_chk(4'd1, sv(8'h77), sv(8'h41));
      read_chk(4'd9, sv(8'h29), sv(8'h89));
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      check("short_ack_ready", {31'd0, frame_ready}, 0);
      check("short_ack_flag", {31'd0, short_frame}, 0);

      // Reset at write 10 of a new frame, asserted between edges.
      rd_addr = 4'd1;
      run     = 1'b1;
      tick();
      for (int k = 0; k < 10; k++) wr(1'b0, 4'(k), 8'hE0 + 8'(k));
      #2 reset = 1'b1;
      #1;
      check("midrst_rd_re", {24'd0, rd_re}, 0);
      check("midrst_rd_im", {24'd0, rd_im}, 0);
      check("midrst_frame_ready", {31'd0, frame_ready}, 0);
      check("midrst_short", {31'd0, short_frame}, 0);
      check("midrst_overflow", {31'd0, overflow}, 0);
      run = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("post_rst_idle", {31'd0, frame_ready}, 0);

      full_frame(8'h30, 8'hC0);
      check("rec_frame_ready", {31'd0, frame_ready}, 1);
      check("rec_short_frame", {31'd0, short_frame}, 0);
      for (int k = 0; k < 16; k++) read_chk(4'(k), sv(8'h30 + 8'(k)), sv(8'hC0 + 8'(k)));

      // Back-to-back full frame: the write counter must restart on entry to FILL.
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      full_frame(8'h50, 8'h00);
      check("b2b_frame_ready", {31'd0, frame_ready}, 1);
      check("b2b_short_frame", {31'd0, short_frame}, 0);
      read_chk(4'd0, sv(8'h50), sv(8'h00));
      read_chk(4'd15, sv(8'h5F), sv(8'h0F));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
